// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller: forward selects, the load result-source
// code, memory-wait FSM states and a register-match helper that ignores x0.
package hazard_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MEMWAIT = 1'b1
  } hazState_t;

  // x0 is hardwired to zero, so a write to it can never be a dependency source.
  function automatic logic regMatch(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// One EX-stage forwarding mux select: the Memory stage outranks Writeback because it
// carries the younger value of the same register.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] RsE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       regWriteM,
  input  logic       regWriteW,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (regWriteM && regMatch(RdM, RsE)) begin
      sel = FWD_M;
    end else if (regWriteW && regMatch(RdW, RsE)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, EX forwarding and a
// memory-wait freeze with sticky timeout. Define HAZARD_PERF_EN for stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = $clog2(MEM_TIMEOUT) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [1:0] resultSrcE,
  input  logic       PCSrcE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       regWriteM,
  input  logic       regWriteW,
  input  logic       memReqM,
  input  logic       memReadyM,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic       flushW,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       memErr
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stallCnt,
  output logic [31:0] flushCnt
`endif
);

  hazState_t        r_state;
  hazState_t        w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic             r_memErr;
  logic             w_freeze;
  logic             w_timeout;
  logic             w_lwStall;
  logic [1:0]       w_fwdA;
  logic [1:0]       w_fwdB;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_cnt    <= '0;
      r_memErr <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      if (w_timeout) begin
        r_memErr <= 1'b1;
      end
    end
  end

  // Next state plus all stall/flush controls; a freeze masks load-use and branch handling.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_freeze    = 1'b0;
    w_timeout   = 1'b0;
    stallF      = 1'b0;
    stallD      = 1'b0;
    stallE      = 1'b0;
    stallM      = 1'b0;
    flushD      = 1'b0;
    flushE      = 1'b0;
    flushW      = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (memReqM && !memReadyM) begin
          w_freeze    = 1'b1;
          w_stateNext = ST_MEMWAIT;
          w_cntNext   = CNT_W'(1);
        end
      end
      ST_MEMWAIT: begin
        w_timeout = (r_cnt == CNT_W'(MEM_TIMEOUT - 1)) && !memReadyM;
        if (memReadyM || w_timeout) begin
          w_stateNext = ST_RUN;
          w_cntNext   = '0;
        end else begin
          w_freeze  = 1'b1;
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_stateNext = ST_RUN;
        w_cntNext   = '0;
      end
    endcase

    w_lwStall = (resultSrcE == RES_LOAD) && (regMatch(RdE, Rs1D) || regMatch(RdE, Rs2D))
                && !PCSrcE;

    if (rst) begin
      w_freeze = 1'b0;
    end else if (w_freeze) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else begin
      stallF = w_lwStall;
      stallD = w_lwStall;
      flushD = PCSrcE;
      flushE = w_lwStall | PCSrcE;
    end
  end

  hazard_fwd_sel u_fwdA (
    .RsE       (Rs1E),
    .RdM       (RdM),
    .RdW       (RdW),
    .regWriteM (regWriteM),
    .regWriteW (regWriteW),
    .sel       (w_fwdA)
  );

  hazard_fwd_sel u_fwdB (
    .RsE       (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .regWriteM (regWriteM),
    .regWriteW (regWriteW),
    .sel       (w_fwdB)
  );

  assign forwardAE = rst ? FWD_RF : w_fwdA;
  assign forwardBE = rst ? FWD_RF : w_fwdB;
  assign memErr    = r_memErr;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stallCnt;
  logic [31:0] r_flushCnt;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (stallF) begin
        r_stallCnt <= r_stallCnt + 32'd1;
      end
      if (flushD) begin
        r_flushCnt <= r_flushCnt + 32'd1;
      end
    end
  end

  assign stallCnt = r_stallCnt;
  assign flushCnt = r_flushCnt;
`endif

endmodule
